ahb_arbiter_slave_3: RTL and testbench

Per-slave AHB arbiter for slave_3. It chooses which requesting master channel owns the slave's address phase. It drives the one-hot select of the slave-side payload mux and a registered data-phase select for the response path. Fairness is round-robin. Ownership is held for a whole fixed-length burst, an undefined-length INCR burst, and a locked sequence.

---
 rtl/ahb_arbiter_slave_3.sv | 196 +++++++++++++++++++
 tb/tb_ahb_arbiter_slave_3.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_slave_3.sv
// Per-slave AHB arbiter for slave_3.
// Picks which master channel owns the slave's address phase, round-robin.
// The owner keeps the slave for a whole fixed-length burst, an undefined
// INCR burst (released on IDLE), or a locked sequence (released on an
// unlocked IDLE).
//
// Handshake: hready_in is the only accept qualifier. An address-phase
// transfer from the owner counts as accepted on a rising HCLK edge where
// hready_in=1. On edges with hready_in=0 every piece of arbiter state
// (grant, data-phase grant, beat counter, state, pointer, lock) holds.
module ahb_arbiter_slave_3 #(
  parameter int CHANNEL_NUM = 2,
  parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [CHANNEL_NUM-1:0]       hreq,
  input  logic [CHANNEL_NUM-1:0]       hlock,
  input  logic [CHANNEL_NUM-1:0][1:0]  htrans,
  input  logic [CHANNEL_NUM-1:0][2:0]  hburst,
  input  logic                         hready_in,
  output logic [CHANNEL_NUM-1:0]       hgrant,
  output logic [CHANNEL_NUM-1:0]       hgrant_data,
  output logic [IDX_W-1:0]             hmaster,
  output logic                         hmastlock,
  output logic [1:0]                   dbg_state,
  output logic [3:0]                   dbg_beat_cnt
);

  typedef enum logic [1:0] {
    NO_OWNER = 2'd0,
    OWNED    = 2'd1,
    BURST    = 2'd2,
    LOCKED   = 2'd3
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;

  state_t                   state;
  state_t                   state_next;
  logic [3:0]               beat_cnt;
  logic [3:0]               cnt_next;
  logic                     undef;
  logic                     undef_next;
  logic [IDX_W-1:0]         rr_ptr;

  logic [1:0]               own_trans;
  logic [2:0]               own_burst;
  logic                     own_lock;
  logic [3:0]               burst_last;
  logic                     is_idle;
  logic                     is_seq;
  logic                     is_nonseq;
  logic                     starts_burst;
  logic                     arb_hold;
  logic                     arb_ok;

  logic                     winner_found;
  logic [IDX_W-1:0]         winner_idx;
  logic [CHANNEL_NUM-1:0]   winner_onehot;
  int                       cand;

  assign dbg_state    = state;
  assign dbg_beat_cnt = beat_cnt;

  // Select the current owner's transfer attributes through the one-hot grant.
  always_comb begin
    own_trans = '0;
    own_burst = '0;
    own_lock  = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (hgrant[i]) begin
        own_trans = own_trans | htrans[i];
        own_burst = own_burst | hburst[i];
        own_lock  = own_lock  | hlock[i];
      end
    end
  end

  assign is_idle      = (own_trans == TRANS_IDLE);
  assign is_seq       = (own_trans == TRANS_SEQ);
  assign is_nonseq    = (own_trans == TRANS_NONSEQ);
  // A NONSEQ with anything other than SINGLE opens a multi-beat sequence.
  assign starts_burst = is_nonseq && (own_burst != BURST_SINGLE);

  // Remaining-beat load value for a fixed-length burst (L-1).
  always_comb begin
    case (own_burst)
      3'd2, 3'd3: burst_last = 4'd3;
      3'd4, 3'd5: burst_last = 4'd7;
      3'd6, 3'd7: burst_last = 4'd15;
      default:    burst_last = 4'd0;
    endcase
  end

  // Decide whether the owner's current transfer forbids re-arbitration.
  always_comb begin
    arb_hold = 1'b0;
    case (state)
      NO_OWNER: arb_hold = 1'b0;
      OWNED:    arb_hold = own_lock || starts_burst;
      BURST: begin
        if (own_lock)       arb_hold = 1'b1;
        else if (is_idle)   arb_hold = 1'b0;
        else if (is_seq)    arb_hold = undef || (beat_cnt > 4'd1);
        else if (is_nonseq) arb_hold = starts_burst;
        else                arb_hold = 1'b1;
      end
      LOCKED:   arb_hold = own_lock || !is_idle;
      default:  arb_hold = 1'b0;
    endcase
  end

  assign arb_ok = hready_in && !arb_hold;

  // Beat counter / undefined-length flag update for an accepted owner transfer.
  always_comb begin
    cnt_next   = beat_cnt;
    undef_next = undef;
    if (is_nonseq) begin
      if (own_burst == BURST_INCR) begin
        cnt_next   = 4'd0;
        undef_next = 1'b1;
      end else begin
        cnt_next   = burst_last;
        undef_next = 1'b0;
      end
    end else if (is_seq && (beat_cnt != 4'd0)) begin
      cnt_next = beat_cnt - 4'd1;
    end
  end

  // State the current owner moves to when it keeps the slave.
  always_comb begin
    state_next = state;
    if (own_lock)                state_next = LOCKED;
    else if (state == LOCKED)    state_next = LOCKED;
    else if (starts_burst)       state_next = BURST;
  end

  // Round-robin search over requests starting just after the last winner.
  always_comb begin
    winner_found  = 1'b0;
    winner_idx    = '0;
    winner_onehot = '0;
    cand          = 0;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      cand = (int'(rr_ptr) + k) % CHANNEL_NUM;
      if (!winner_found && hreq[cand]) begin
        winner_found  = 1'b1;
        winner_idx    = IDX_W'(cand);
        winner_onehot = '0;
        winner_onehot[cand] = 1'b1;
      end
    end
  end

  // Arbiter FSM with registered grant, data-phase grant, index and lock.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= NO_OWNER;
      hgrant      <= '0;
      hgrant_data <= '0;
      hmaster     <= '0;
      hmastlock   <= 1'b0;
      beat_cnt    <= 4'd0;
      undef       <= 1'b0;
      rr_ptr      <= IDX_W'(CHANNEL_NUM - 1);
    end else if (hready_in) begin
      hgrant_data <= hgrant;
      hmastlock   <= own_lock;
      beat_cnt    <= cnt_next;
      undef       <= undef_next;
      if (arb_ok) begin
        if (winner_found) begin
          hgrant  <= winner_onehot;
          rr_ptr  <= winner_idx;
          hmaster <= winner_idx;
          state   <= OWNED;
        end else begin
          hgrant  <= '0;
          state   <= NO_OWNER;
        end
      end else begin
        state <= state_next;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_slave_3.sv
// Self-checking bench for ahb_arbiter_slave_3 (two channels).
module tb_ahb_arbiter_slave_3;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

  logic            HCLK;
  logic            HRESETn;
  logic [1:0]      hreq;
  logic [1:0]      hlock;
  logic [1:0][1:0] htrans;
  logic [1:0][2:0] hburst;
  logic            hready_in;
  logic [1:0]      hgrant;
  logic [1:0]      hgrant_data;
  logic [0:0]      hmaster;
  logic            hmastlock;
  logic [1:0]      dbg_state;
  logic [3:0]      dbg_beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // per-channel transaction plans for the randomized run
  int         op_kind[2];
  int         op_len[2];
  int         op_pos[2];
  int         op_busy_at[2];
  bit         op_busy_done[2];
  logic [2:0] op_code[2];
  logic [1:0] exp_q[$];

  ahb_arbiter_slave_3 #(.CHANNEL_NUM(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hreq(hreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready_in(hready_in),
    .hgrant(hgrant), .hgrant_data(hgrant_data), .hmaster(hmaster),
    .hmastlock(hmastlock), .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
  );

  // clock
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    hreq = '0; hlock = '0; htrans = '0; hburst = '0; hready_in = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESETn = 1'b0;
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESETn = 1'b0;
    hreq = 2'b11;
    htrans[0] = T_NONSEQ; htrans[1] = T_NONSEQ;
    tick();
    tick();
    n_checks++; if (hgrant !== 2'b00) begin n_errors++; $display("FAIL reset_hgrant: got %b expected 00", hgrant); end
    n_checks++; if (hgrant_data !== 2'b00) begin n_errors++; $display("FAIL reset_hgrant_data: got %b expected 00", hgrant_data); end
    n_checks++; if (hmaster !== 1'b0) begin n_errors++; $display("FAIL reset_hmaster: got %b expected 0", hmaster); end
    n_checks++; if (hmastlock !== 1'b0) begin n_errors++; $display("FAIL reset_hmastlock: got %b expected 0", hmastlock); end
    n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_checks++; if (dbg_beat_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_beat_cnt: got %0d expected 0", dbg_beat_cnt); end
    HRESETn = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g[4];
    logic [1:0] prev;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    prev = 2'b00;
    do_reset();
    hreq = 2'b11;
    htrans[0] = T_NONSEQ; htrans[1] = T_NONSEQ;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (hgrant !== exp_g[i]) begin n_errors++; $display("FAIL rr_hgrant cycle %0d: got %b expected %b", i, hgrant, exp_g[i]); end
      n_checks++; if (hgrant_data !== prev) begin n_errors++; $display("FAIL rr_hgrant_data cycle %0d: got %b expected %b", i, hgrant_data, prev); end
      n_checks++; if (hmaster !== exp_g[i][1]) begin n_errors++; $display("FAIL rr_hmaster cycle %0d: got %b expected %b", i, hmaster, exp_g[i][1]); end
      prev = exp_g[i];
    end
  endtask

  // ch0 INCR4 against a waiting ch1; optional 3-cycle stall after the 2nd beat
  task automatic run_incr4(input bit stall, input string tag);
    int switch_at;
    int cyc;
    int beat;
    do_reset();
    hreq = 2'b11;
    htrans[1] = T_NONSEQ;
    tick();
    n_checks++; if (hgrant !== 2'b01) begin n_errors++; $display("FAIL %s_first_grant: got %b expected 01", tag, hgrant); end
    switch_at = -1;
    beat = 0;
    for (cyc = 1; cyc <= 12 && beat < 4; cyc++) begin
      hburst[0] = 3'd3;
      htrans[0] = (beat == 0) ? T_NONSEQ : T_SEQ;
      hready_in = !(stall && beat == 2 && cyc <= 5);
      tick();
      if (hready_in) beat++;
      if (!hready_in) begin
        n_checks++; if (hgrant !== 2'b01 || hgrant_data !== 2'b01) begin n_errors++; $display("FAIL %s_stall_grants cycle %0d: got %b/%b expected 01/01", tag, cyc, hgrant, hgrant_data); end
        n_checks++; if (dbg_beat_cnt !== 4'd2) begin n_errors++; $display("FAIL %s_stall_cnt cycle %0d: got %0d expected 2", tag, cyc, dbg_beat_cnt); end
      end else if (beat < 4) begin
        n_checks++; if (hgrant !== 2'b01) begin n_errors++; $display("FAIL %s_hold cycle %0d: got %b expected 01", tag, cyc, hgrant); end
        n_checks++; if (dbg_beat_cnt !== 4'(4 - beat)) begin n_errors++; $display("FAIL %s_cnt cycle %0d: got %0d expected %0d", tag, cyc, dbg_beat_cnt, 4 - beat); end
      end
      if (hgrant == 2'b10 && switch_at < 0) switch_at = cyc;
    end
    n_checks++; if (hgrant !== 2'b10) begin n_errors++; $display("FAIL %s_switch_grant: got %b expected 10", tag, hgrant); end
    n_checks++; if (switch_at !== (stall ? 7 : 4)) begin n_errors++; $display("FAIL %s_switch_cycle: got %0d expected %0d", tag, switch_at, stall ? 7 : 4); end
    n_checks++; if (hgrant_data !== 2'b01) begin n_errors++; $display("FAIL %s_data_after_switch: got %b expected 01", tag, hgrant_data); end
  endtask

  task automatic test_fixed_burst();
    run_incr4(1'b0, "incr4");
  endtask

  task automatic test_stall();
    run_incr4(1'b1, "stall");
  endtask

  task automatic test_locked();
    do_reset();
    hreq = 2'b10;
    tick();
    n_checks++; if (hgrant !== 2'b10) begin n_errors++; $display("FAIL lock_first_grant: got %b expected 10", hgrant); end
    hreq = 2'b11;
    htrans[0] = T_NONSEQ;
    for (int i = 0; i < 3; i++) begin
      htrans[1] = T_NONSEQ; hburst[1] = 3'd0; hlock[1] = 1'b1;
      hready_in = 1'b1;
      tick();
      n_checks++; if (hgrant !== 2'b10 || hmastlock !== 1'b1) begin n_errors++; $display("FAIL lock_hold beat %0d: got grant %b lock %b expected 10 1", i, hgrant, hmastlock); end
      if (i == 0) begin
        hready_in = 1'b0;
        tick();
        n_checks++; if (hgrant !== 2'b10 || hmastlock !== 1'b1) begin n_errors++; $display("FAIL lock_stall: got grant %b lock %b expected 10 1", hgrant, hmastlock); end
      end
    end
    htrans[1] = T_IDLE; hlock[1] = 1'b0;
    hready_in = 1'b0;
    tick();
    n_checks++; if (hgrant !== 2'b10) begin n_errors++; $display("FAIL lock_idle_unaccepted: got %b expected 10", hgrant); end
    hready_in = 1'b1;
    tick();
    n_checks++; if (hgrant !== 2'b01) begin n_errors++; $display("FAIL lock_release: got %b expected 01", hgrant); end
    n_checks++; if (hmastlock !== 1'b0) begin n_errors++; $display("FAIL lock_release_mastlock: got %b expected 0", hmastlock); end
  endtask

  task automatic test_undef_incr();
    do_reset();
    hreq = 2'b11;
    htrans[1] = T_NONSEQ;
    tick();
    hburst[0] = 3'd1;
    for (int i = 0; i < 7; i++) begin
      htrans[0] = (i == 0) ? T_NONSEQ : T_SEQ;
      tick();
      n_checks++; if (hgrant !== 2'b01) begin n_errors++; $display("FAIL undef_hold beat %0d: got %b expected 01", i, hgrant); end
    end
    htrans[0] = T_IDLE;
    tick();
    n_checks++; if (hgrant !== 2'b10) begin n_errors++; $display("FAIL undef_release: got %b expected 10", hgrant); end
  endtask

  task automatic test_async_reset();
    do_reset();
    hreq = 2'b11;
    htrans[1] = T_NONSEQ;
    tick();
    hburst[0] = 3'd5; hlock[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      htrans[0] = (i == 0) ? T_NONSEQ : T_SEQ;
      tick();
    end
    n_checks++; if (dbg_beat_cnt !== 4'd5) begin n_errors++; $display("FAIL areset_pre_cnt: got %0d expected 5", dbg_beat_cnt); end
    n_checks++; if (hgrant_data !== 2'b01 || hmastlock !== 1'b1) begin n_errors++; $display("FAIL areset_pre: got data %b lock %b expected 01 1", hgrant_data, hmastlock); end
    #2;
    HRESETn = 1'b0;
    #1;
    n_checks++; if (hgrant !== 2'b00 || hgrant_data !== 2'b00 || hmastlock !== 1'b0) begin n_errors++; $display("FAIL areset_outputs: got %b/%b/%b expected 00/00/0", hgrant, hgrant_data, hmastlock); end
    n_checks++; if (dbg_beat_cnt !== 4'd0) begin n_errors++; $display("FAIL areset_cnt: got %0d expected 0", dbg_beat_cnt); end
    htrans = '0; hlock = '0; hburst = '0;
    #2;
    HRESETn = 1'b1;
    tick();
    n_checks++; if (hgrant !== 2'b01) begin n_errors++; $display("FAIL areset_first_grant: got %b expected 01", hgrant); end
  endtask

  // draw a new transaction plan for a channel
  function automatic void new_op(input int ch);
    int c;
    op_kind[ch] = int'($urandom_range(0, 3));
    op_pos[ch] = 0;
    op_busy_done[ch] = 1'b0;
    op_busy_at[ch] = -1;
    case (op_kind[ch])
      0: begin op_len[ch] = 1; op_code[ch] = 3'd0; end
      1: begin
        c = int'($urandom_range(1, 3));
        op_len[ch] = 2 << c;
        op_code[ch] = 3'(2 * c + int'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) op_busy_at[ch] = int'($urandom_range(1, op_len[ch] - 1));
      end
      2: begin op_len[ch] = int'($urandom_range(1, 6)); op_code[ch] = 3'd1; end
      default: begin op_len[ch] = int'($urandom_range(1, 3)); op_code[ch] = 3'd0; end
    endcase
  endfunction

  // the transfer a channel presents at its current plan position
  task automatic op_transfer(input int ch, output logic [1:0] tr, output logic [2:0] bu,
                             output logic lk, output bit ends, output bit busy);
    int p;
    p = op_pos[ch];
    ends = 1'b0; busy = 1'b0; lk = 1'b0; bu = op_code[ch]; tr = T_IDLE;
    case (op_kind[ch])
      0: begin tr = T_NONSEQ; ends = 1'b1; end
      1: begin
        if (p > 0 && p == op_busy_at[ch] && !op_busy_done[ch]) begin tr = T_BUSY; busy = 1'b1; end
        else begin tr = (p == 0) ? T_NONSEQ : T_SEQ; ends = (p == op_len[ch] - 1); end
      end
      2: begin
        if (p == op_len[ch]) begin tr = T_IDLE; ends = 1'b1; end
        else tr = (p == 0) ? T_NONSEQ : T_SEQ;
      end
      default: begin
        if (p == op_len[ch]) begin tr = T_IDLE; ends = 1'b1; bu = 3'd0; end
        else begin tr = T_NONSEQ; lk = 1'b1; end
      end
    endcase
  endtask

  task automatic test_random();
    int owner, data_owner, ptr, master, found, c;
    logic exp_lock, cur_lock;
    logic [1:0] cur_trans, exp_g, exp_d, got;
    logic [2:0] cur_burst;
    bit ends, busy;
    do_reset();
    owner = -1; data_owner = -1; ptr = 1; master = 0; exp_lock = 1'b0;
    for (int ch = 0; ch < 2; ch++) new_op(ch);
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int ch = 0; ch < 2; ch++) begin
        hreq[ch] = ($urandom_range(0, 9) < 7);
        htrans[ch] = 2'($urandom_range(0, 3));
        hburst[ch] = 3'($urandom_range(0, 7));
        hlock[ch] = 1'($urandom_range(0, 1));
      end
      hready_in = ($urandom_range(0, 4) != 0);
      cur_lock = 1'b0; ends = 1'b0; busy = 1'b0;
      if (owner >= 0) begin
        op_transfer(owner, cur_trans, cur_burst, cur_lock, ends, busy);
        htrans[owner] = cur_trans; hburst[owner] = cur_burst; hlock[owner] = cur_lock;
      end
      if (hready_in) begin
        data_owner = owner;
        exp_lock = cur_lock;
        if (owner >= 0) begin
          if (busy) op_busy_done[owner] = 1'b1;
          else op_pos[owner]++;
          if (ends) new_op(owner);
        end
        if (owner < 0 || ends) begin
          found = -1;
          for (int k = 1; k <= 2; k++) begin
            c = (ptr + k) % 2;
            if (found < 0 && hreq[c]) found = c;
          end
          owner = found;
          if (found >= 0) begin ptr = found; master = found; end
        end
      end
      exp_g = (owner >= 0) ? 2'(1 << owner) : 2'b00;
      exp_q.push_back(exp_g);
      tick();
      got = exp_q.pop_front();
      exp_d = (data_owner >= 0) ? 2'(1 << data_owner) : 2'b00;
      n_checks++; if (hgrant !== got) begin n_errors++; $display("FAIL rand_hgrant cycle %0d: got %b expected %b", cyc, hgrant, got); end
      n_checks++; if (hgrant_data !== exp_d) begin n_errors++; $display("FAIL rand_hgrant_data cycle %0d: got %b expected %b", cyc, hgrant_data, exp_d); end
      n_checks++; if (hmastlock !== exp_lock) begin n_errors++; $display("FAIL rand_hmastlock cycle %0d: got %b expected %b", cyc, hmastlock, exp_lock); end
      if (owner >= 0) begin
        n_checks++; if (hmaster !== 1'(master)) begin n_errors++; $display("FAIL rand_hmaster cycle %0d: got %b expected %0d", cyc, hmaster, master); end
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_fixed_burst();
    test_stall();
    test_locked();
    test_undef_incr();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
